// File: rtl/nic_ring_ctrl.sv
// Ring-node controller: classifies each ring slot, extracts packets addressed here into an rx FIFO,
// drops returning packets, and injects one held local packet into free slots (or loops it back).
package nic_ring_pkg;
    localparam logic [1:0] PT_NULL = 2'd0;

    typedef struct packed {
        logic [5:0]  did;
        logic [5:0]  sid;
        logic [1:0]  typ;
        logic [15:0] payload;
    } packet_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] data;
    } ipacket_t;
endpackage

// state   | meaning
// TX_IDLE | holding register empty, tx_ready_o high
// TX_PEND | local packet held, waiting for a free slot (or FIFO room when looping back)
module nic_ring_ctrl
    import nic_ring_pkg::*;
#(
    parameter logic [5:0] MY_ID      = 6'd1,
    parameter int         RXQ_DEPTH  = 4,
    parameter int         STARVE_LIM = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  packet_t       packet_i,
    output packet_t       packet_o,
    input  ipacket_t      ipacket_i,
    output ipacket_t      ipacket_o,
    input  logic          tx_valid_i,
    output logic          tx_ready_o,
    input  packet_t       tx_pkt_i,
    output logic          rx_valid_o,
    input  logic          rx_ready_i,
    output packet_t       rx_pkt_o,
    output logic          starve_o,
    output logic [15:0]   rx_cnt_o,
    output logic [15:0]   tx_cnt_o,
    output logic [15:0]   drop_cnt_o
);

    localparam int PW = (RXQ_DEPTH > 1) ? $clog2(RXQ_DEPTH) : 1;
    localparam int CW = $clog2(RXQ_DEPTH + 1);
    localparam int WW = $clog2(STARVE_LIM + 1);

    typedef enum logic {TX_IDLE, TX_PEND} state_e;

    state_e          state_q, state_d;
    packet_t         hold_q, hold_d;
    logic [WW-1:0]   wait_q, wait_d;
    packet_t         pkt_q, pkt_d;
    ipacket_t        ipkt_q;
    packet_t         mem_q [RXQ_DEPTH];
    packet_t         mem_d [RXQ_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, drop_cnt_q, drop_cnt_d;

    logic slot_empty, slot_mine, slot_ret, slot_free;
    logic fifo_full, fifo_empty;
    logic extract, drop, loopback, inject, tx_done, tx_load;
    logic push, pop;
    packet_t push_pkt;

    // Fullness is judged on the pre-pop count, so a pop never makes room in the same cycle.
    always_comb begin
        slot_empty = (packet_i.typ == PT_NULL);
        slot_mine  = !slot_empty && (packet_i.did == MY_ID);
        slot_ret   = !slot_empty && (packet_i.sid == MY_ID) && (packet_i.did != MY_ID);
        fifo_full  = (cnt_q == CW'(RXQ_DEPTH));
        fifo_empty = (cnt_q == '0);
        extract    = en_i && slot_mine && !fifo_full;
        drop       = en_i && slot_ret;
        slot_free  = en_i && (slot_empty || extract || drop);
        loopback   = en_i && (state_q == TX_PEND) && (hold_q.did == MY_ID) && !extract && !fifo_full;
        inject     = en_i && (state_q == TX_PEND) && (hold_q.did != MY_ID) && slot_free;
        tx_done    = loopback || inject;
        push       = extract || loopback;
        push_pkt   = extract ? packet_i : hold_q;
        rx_valid_o = rst_ni && !fifo_empty;
        pop        = rx_valid_o && rx_ready_i;
        tx_ready_o = rst_ni && (state_q == TX_IDLE);
        tx_load    = tx_valid_i && tx_ready_o;
        starve_o   = rst_ni && (wait_q == WW'(STARVE_LIM));
        rx_pkt_o   = mem_q[rd_ptr_q];
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wait_d  = wait_q;
        case (state_q)
            TX_IDLE: begin
                wait_d = '0;
                if (tx_load) begin
                    hold_d  = tx_pkt_i;
                    state_d = TX_PEND;
                end
            end
            TX_PEND: begin
                if (tx_done) begin
                    state_d = TX_IDLE;
                    wait_d  = '0;
                end else if (wait_q != WW'(STARVE_LIM)) begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        pkt_d = packet_i;
        if (inject)
            pkt_d = hold_q;
        else if (slot_free)
            pkt_d = '0;

        mem_d = mem_q;
        if (push)
            mem_d[wr_ptr_q] = push_pkt;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);

        rx_cnt_d   = rx_cnt_q + 16'(push);
        tx_cnt_d   = tx_cnt_q + 16'(tx_done);
        drop_cnt_d = drop_cnt_q + 16'(drop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= TX_IDLE;
            hold_q     <= '0;
            wait_q     <= '0;
            pkt_q      <= '0;
            ipkt_q     <= '0;
            for (int i = 0; i < RXQ_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            wait_q     <= wait_d;
            pkt_q      <= pkt_d;
            ipkt_q     <= ipacket_i;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign packet_o   = pkt_q;
    assign ipacket_o  = ipkt_q;
    assign rx_cnt_o   = rx_cnt_q;
    assign tx_cnt_o   = tx_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: doc/nic_ring_ctrl.md
NIC_RING_CTRL -- requirements
Module: nic_ring_ctrl

Interface
REQ-001 SHALL have parameter MY_ID, default 6'd1, this node's ring address.
REQ-002 SHALL have parameter RXQ_DEPTH, default 4, rx FIFO entries (power of two).
REQ-003 SHALL have parameter STARVE_LIM, default 16, local-inject wait threshold in cycles.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset; synchronous and active-low.
REQ-006 en_i  in  1  1 = inject/extract enabled; 0 = pure pass-through.
REQ-007 packet_i  in  Packet  ring slot from upstream stage.
REQ-008 packet_o  out  Packet  ring slot to downstream stage.
REQ-009 ipacket_i  in  IPacket  side-band packet from upstream.
REQ-010 ipacket_o  out  IPacket  side-band packet to downstream.
REQ-011 tx_valid_i / tx_ready_o / tx_pkt_i  in / out / Packet  local transmit handshake.
REQ-012 rx_valid_o / rx_ready_i / rx_pkt_o  out / in / Packet  local receive handshake.
REQ-013 starve_o  out  1  local transmit has waited >= STARVE_LIM cycles.
REQ-014 rx_cnt_o, tx_cnt_o, drop_cnt_o  out  16 each  event counters.
REQ-015 Packet fields used: did[5:0] destination, sid[5:0] source, typ; typ==PT_NULL marks an empty slot.

Function
REQ-016 packet_o and ipacket_o SHALL be registered: exactly 1 cycle latency from packet_i/ipacket_i.
REQ-017 ipacket_o SHALL always equal ipacket_i delayed one cycle, unaffected by en_i.
REQ-018 Slot classification per cycle: EMPTY (typ==PT_NULL), MINE (did==MY_ID), RETURN (sid==MY_ID, did!=MY_ID), TRANSIT (else).
REQ-019 MINE with rx FIFO not full SHALL be extracted into the FIFO, rx_cnt +1, slot becomes free.
REQ-020 MINE with rx FIFO full SHALL pass unchanged to packet_o (recirculate); no counter change.
REQ-021 RETURN SHALL be dropped (slot becomes free), drop_cnt +1.
REQ-022 TRANSIT SHALL pass unchanged; ring traffic always has priority over local inject.
REQ-023 Tx holding register, FSM TX_IDLE/TX_PEND: tx_ready_o = (state==TX_IDLE); tx_valid_i&&tx_ready_o loads tx_pkt_i, goes TX_PEND.
REQ-024 In TX_PEND, a free slot (EMPTY, extracted MINE, or dropped RETURN) SHALL carry the held packet to packet_o same cycle, tx_cnt +1, return to TX_IDLE.
REQ-025 Free slot with no pending tx SHALL output a PT_NULL packet (all other fields 0).
REQ-026 Held tx packet with did==MY_ID SHALL be written to the rx FIFO instead of the ring when not full (loopback), tx_cnt +1 and rx_cnt +1; if full, stays TX_PEND.
REQ-027 Loopback and ring extraction in same cycle: ring extraction wins; loopback retries next cycle.
REQ-028 Wait counter: 0 in TX_IDLE, +1 per TX_PEND cycle without inject, saturates at STARVE_LIM; starve_o = (count==STARVE_LIM); informational only.
REQ-029 Rx FIFO: rx_valid_o = not empty; rx_pkt_o = head (first-word-fall-through); pop on rx_valid_o&&rx_ready_i; simultaneous push and pop when full SHALL NOT be permitted to extract (full test uses pre-pop state).
REQ-030 Counters SHALL wrap modulo 2^16.
REQ-031 en_i==0: no extract, drop or inject; all slots pass unchanged; tx held, FSM stays; FIFO still drains.
REQ-032 Packet fields other than those in REQ-015 SHALL be carried bit-exact.

Reset
REQ-033 rst_ni==0 at a clock edge: packet_o, ipacket_o all-zero; FSM TX_IDLE; FIFO empty; wait count, counters 0.
REQ-034 During reset tx_ready_o=0, rx_valid_o=0, starve_o=0; reset mid-TX_PEND discards held packet without counting.

Verification
REQ-035 MY_ID=1; packet_i did=1 sid=3, FIFO empty -> next cycle packet_o typ=PT_NULL, rx_valid_o=1, rx_cnt_o=1.
REQ-036 FIFO full (4 entries), rx_ready_i=0, packet_i did=1 -> packet_o equals that packet next cycle, rx_cnt_o unchanged.
REQ-037 tx_pkt_i did=5 loaded; 3 TRANSIT slots then EMPTY -> injected on cycle 4, tx_cnt_o=1, tx_ready_o returns 1.
REQ-038 tx pending, packet_i did=1 arrives, FIFO has space -> same-cycle extract and inject; rx_cnt_o=1, tx_cnt_o=1.
REQ-039 20 consecutive TRANSIT slots with tx pending -> starve_o=1 from wait count 16, cleared after injection.
REQ-040 packet_i sid=1 did=7 -> packet_o PT_NULL, drop_cnt_o=1; same with en_i=0 -> passed unchanged, drop_cnt_o=0.
